// File: rtl/vid_timing_pkg.sv
// Shared raster timing constants, trigger table layout and entry type.
package vid_timing_pkg;

    localparam int unsigned CNT_W = 12;
    localparam int unsigned PC_W  = 4;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned TRIG_ENTRIES = 24;
    localparam int unsigned TRIG_STRIDE  = 4;
    localparam int unsigned TRIG_BITS    = 2 * TRIG_ENTRIES;

    typedef struct packed {
        logic [CNT_W-1:0] hx;
        logic [CNT_W-1:0] vy;
    } trig_entry_t;

    function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vid_sync_hv_trigger_gen_if.sv
// Video timing output bundle toward the OSD/layer generator.
interface vid_sync_hv_trigger_gen_if;
    import vid_timing_pkg::*;

    logic [PC_W-1:0]      pc_ena;
    logic [CNT_W-1:0]     h_count;
    logic [CNT_W-1:0]     v_count;
    logic                 hde_out;
    logic                 vde_out;
    logic                 hs_out;
    logic                 vs_out;
    logic [TRIG_BITS-1:0] HV_triggers;

    modport master (
        output pc_ena, h_count, v_count, hde_out, vde_out, hs_out, vs_out, HV_triggers
    );

    modport slave (
        input pc_ena, h_count, v_count, hde_out, vde_out, hs_out, vs_out, HV_triggers
    );

endinterface

// File: rtl/hv_trig_cmp.sv
// One trigger table entry: frame-synchronous shadow copy and H/V position compare.
module hv_trig_cmp
    import vid_timing_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  trig_entry_t      entry,
    input  logic [CNT_W-1:0] h_next,
    input  logic [CNT_W-1:0] v_next,
    output logic             trig_h,
    output logic             trig_v
);

    trig_entry_t shadow_q;
    trig_entry_t cmp_c;

    // On the frame-start pixel the freshly loaded value is already in force.
    assign cmp_c = load ? entry : shadow_q;

    // Shadow capture and registered position match against the next counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            trig_h   <= 1'b0;
            trig_v   <= 1'b0;
        end else begin
            if (load) begin
                shadow_q <= entry;
            end
            trig_h <= (h_next == cmp_c.hx);
            trig_v <= (v_next == cmp_c.vy);
        end
    end

endmodule

// File: rtl/vid_sync_hv_trigger_gen.sv
// Raster timing source: sub-pixel phase, H/V counters, enables, syncs and HV triggers.
module vid_sync_hv_trigger_gen
    import vid_timing_pkg::*;
#(
    parameter int unsigned HW_REGS       = 9,
    parameter int unsigned TRIG_REG_BASE = 0,
    parameter int unsigned PIX_DIV       = 4,
    parameter int unsigned H_ACTIVE      = DEF_H_ACTIVE,
    parameter int unsigned H_FP          = DEF_H_FP,
    parameter int unsigned H_SYNC        = DEF_H_SYNC,
    parameter int unsigned H_BP          = DEF_H_BP,
    parameter int unsigned V_ACTIVE      = DEF_V_ACTIVE,
    parameter int unsigned V_FP          = DEF_V_FP,
    parameter int unsigned V_SYNC        = DEF_V_SYNC,
    parameter int unsigned V_BP          = DEF_V_BP,
    parameter bit          H_SYNC_POL    = 1'b0,
    parameter bit          V_SYNC_POL    = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [8*(2**HW_REGS)-1:0]     GPU_HW_Control_regs,
    vid_sync_hv_trigger_gen_if.master     vid
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [PC_W-1:0]  PC_LAST = PC_W'(PIX_DIV - 1);

    logic [PC_W-1:0]      pc_q;
    logic [CNT_W-1:0]     h_q;
    logic [CNT_W-1:0]     v_q;
    logic                 hde_q;
    logic                 vde_q;
    logic                 hs_q;
    logic                 vs_q;
    logic [TRIG_BITS-1:0] trig;

    logic                 pix_step_c;
    logic                 frame_load_c;
    logic [CNT_W-1:0]     h_next_c;
    logic [CNT_W-1:0]     v_next_c;

    // Register bytes outside the trigger fields are intentionally ignored.
    logic                 unused_regs;
    assign unused_regs = ^GPU_HW_Control_regs;

    // Next raster position; outputs are decoded from it so they align with the counters.
    always_comb begin
        pix_step_c = (pc_q == PC_LAST);
        h_next_c   = h_q;
        v_next_c   = v_q;
        if (pix_step_c) begin
            if (h_q == H_LAST) begin
                h_next_c = '0;
                v_next_c = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
            end else begin
                h_next_c = h_q + CNT_W'(1);
            end
        end
        frame_load_c = pix_step_c && (h_next_c == '0) && (v_next_c == '0);
    end

    // Phase, counters and region decode registers; reset parks on the last back-porch pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= '0;
            h_q   <= H_LAST;
            v_q   <= V_LAST;
            hde_q <= 1'b0;
            vde_q <= 1'b0;
            hs_q  <= ~H_SYNC_POL;
            vs_q  <= ~V_SYNC_POL;
        end else begin
            pc_q  <= pix_step_c ? '0 : pc_q + PC_W'(1);
            h_q   <= h_next_c;
            v_q   <= v_next_c;
            hde_q <= (h_next_c < H_ACT);
            vde_q <= (v_next_c < V_ACT);
            hs_q  <= ((h_next_c >= HS_BEG) && (h_next_c < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
            vs_q  <= ((v_next_c >= VS_BEG) && (v_next_c < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
        end
    end

    // One comparator per table entry; entry k sits at 4 consecutive bytes.
    for (genvar k = 0; k < TRIG_ENTRIES; k++) begin : g_trig
        localparam int unsigned B0 = 8 * (TRIG_REG_BASE + TRIG_STRIDE * k);
        trig_entry_t entry_c;

        assign entry_c.hx = {GPU_HW_Control_regs[B0 + 8 +: 4],  GPU_HW_Control_regs[B0 +: 8]};
        assign entry_c.vy = {GPU_HW_Control_regs[B0 + 24 +: 4], GPU_HW_Control_regs[B0 + 16 +: 8]};

        hv_trig_cmp u_cmp (
            .clk    (clk),
            .rst_n  (rst_n),
            .load   (frame_load_c),
            .entry  (entry_c),
            .h_next (h_next_c),
            .v_next (v_next_c),
            .trig_h (trig[2*k]),
            .trig_v (trig[2*k+1])
        );
    end

    assign vid.pc_ena      = pc_q;
    assign vid.h_count     = h_q;
    assign vid.v_count     = v_q;
    assign vid.hde_out     = hde_q;
    assign vid.vde_out     = vde_q;
    assign vid.hs_out      = hs_q;
    assign vid.vs_out      = vs_q;
    assign vid.HV_triggers = trig;

endmodule
